// File: rtl/mem_byte_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_seq_pkg
// Description : Shared encodings for the byte-serial memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_byte_seq_pkg;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;

    localparam int RAM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RD_TAIL = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    // Index of the final beat; width code 3 behaves as a word.
    function automatic logic [1:0] beat_last(input logic [1:0] width);
        case (width)
            WIDTH_B: return 2'd0;
            WIDTH_H: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_seq_if
// Description : Request/response handshake and 8-bit RAM bus of mem_byte_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_byte_seq_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req_in;
    logic [ADDR_W-1:0] inst_addr_in;
    logic              inst_done_out;
    logic [31:0]       inst_data_out;

    logic              data_req_in;
    logic              data_rw_in;
    logic [1:0]        data_width_in;
    logic              data_sext_in;
    logic [ADDR_W-1:0] data_addr_in;
    logic [31:0]       data_wdata_in;
    logic              data_done_out;
    logic [31:0]       data_rdata_out;

    logic [ADDR_W-1:0] ram_a_out;
    logic [7:0]        ram_dout_out;
    logic              ram_wr_out;
    logic [7:0]        ram_din_in;

    logic              busy_out;

    modport slave (
        input  inst_req_in, inst_addr_in,
        input  data_req_in, data_rw_in, data_width_in, data_sext_in,
        input  data_addr_in, data_wdata_in,
        input  ram_din_in,
        output inst_done_out, inst_data_out,
        output data_done_out, data_rdata_out,
        output ram_a_out, ram_dout_out, ram_wr_out,
        output busy_out
    );

    modport master (
        output inst_req_in, inst_addr_in,
        output data_req_in, data_rw_in, data_width_in, data_sext_in,
        output data_addr_in, data_wdata_in,
        output ram_din_in,
        input  inst_done_out, inst_data_out,
        input  data_done_out, data_rdata_out,
        input  ram_a_out, ram_dout_out, ram_wr_out,
        input  busy_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_byte_seq_ld_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_ld_extend
// Description : Turns the assembled load bytes into a 32-bit zero/sign-extended result.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ld_extend
    import mem_byte_seq_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [1:0]  width_i,
    input  logic        sext_i,
    output logic [31:0] result_o
);
    always_comb begin
        result_o = asm_i;
        case (width_i)
            WIDTH_B: result_o = {{24{sext_i & asm_i[7]}}, asm_i[7:0]};
            WIDTH_H: result_o = {{16{sext_i & asm_i[15]}}, asm_i[15:0]};
            default: result_o = asm_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_byte_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_seq
// Description : Serialises word-level fetch/load/store requests onto an 8-bit RAM bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_seq
    import mem_byte_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    mem_byte_seq_if.slave  bus
);
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    src_t              src_q;
    logic              store_q;
    logic [1:0]        width_q;
    logic              sext_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic              cap_vld_q;
    logic [1:0]        cap_idx_q;
    logic [31:0]       asm_q;
    logic [31:0]       inst_data_q;
    logic [31:0]       rdata_q;

    logic              w_accept;
    logic              w_cap;
    logic [31:0]       w_asm;
    logic [31:0]       w_ext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (bus.data_req_in || bus.inst_req_in) begin
                        w_accept = 1'b1;
                        state_d  = XFER;
                        cnt_d    = 2'd0;
                    end
                end
                XFER: begin
                    if (cnt_q == beat_last(width_q)) begin
                        cnt_d   = 2'd0;
                        state_d = store_q ? DONE : RD_TAIL;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                RD_TAIL: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Read byte for the beat issued last cycle is merged here.
    assign w_cap = cap_vld_q && rdy;

    always_comb begin
        w_asm = asm_q;
        if (w_cap) begin
            w_asm[{cap_idx_q, 3'b000} +: 8] = bus.ram_din_in;
        end
    end

    mem_ld_extend u_ext (
        .asm_i    (w_asm),
        .width_i  (width_q),
        .sext_i   (sext_q),
        .result_o (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            src_q       <= SRC_INST;
            store_q     <= 1'b0;
            width_q     <= WIDTH_B;
            sext_q      <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= 2'd0;
            asm_q       <= '0;
            inst_data_q <= '0;
            rdata_q     <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_vld_q <= (state_q == XFER) && !store_q;
            cap_idx_q <= cnt_q;
            asm_q     <= w_asm;
            if (w_accept) begin
                asm_q <= '0;
                if (bus.data_req_in) begin
                    src_q   <= SRC_DATA;
                    store_q <= bus.data_rw_in;
                    width_q <= bus.data_width_in;
                    sext_q  <= bus.data_sext_in;
                    base_q  <= bus.data_addr_in;
                    wdata_q <= bus.data_wdata_in;
                end else begin
                    src_q   <= SRC_INST;
                    store_q <= 1'b0;
                    width_q <= WIDTH_W;
                    sext_q  <= 1'b0;
                    base_q  <= bus.inst_addr_in;
                    wdata_q <= '0;
                end
            end
            if (state_q == RD_TAIL) begin
                if (src_q == SRC_INST) begin
                    inst_data_q <= w_ext;
                end else begin
                    rdata_q <= w_ext;
                end
            end
        end
    end

    // While stalled with a read byte pending, re-present its address so the
    // RAM still returns that byte on the first cycle after rdy returns.
    always_comb begin
        bus.ram_a_out = '0;
        if (cap_vld_q && !rdy) begin
            bus.ram_a_out = base_q + ADDR_W'(cap_idx_q);
        end else if (state_q == XFER) begin
            bus.ram_a_out = base_q + ADDR_W'(cnt_q);
        end
    end

    assign bus.ram_wr_out     = (state_q == XFER) && store_q && rdy && !rst;
    assign bus.ram_dout_out   = ((state_q == XFER) && store_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
    assign bus.inst_done_out  = (state_q == DONE) && (src_q == SRC_INST) && rdy && !rst;
    assign bus.data_done_out  = (state_q == DONE) && (src_q == SRC_DATA) && rdy && !rst;
    assign bus.inst_data_out  = inst_data_q;
    assign bus.data_rdata_out = rdata_q;
    assign bus.busy_out       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_seq
// Description : Directed self-checking bench for mem_byte_seq with a 1-cycle RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_seq;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_total = 0;
    int   n_bad   = 0;

    mem_byte_seq_if #(.ADDR_W(32)) bus ();

    mem_byte_seq #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:8191];
    logic [7:0] r_din;

    always @(posedge clk) begin
        if (bus.ram_wr_out) mem[bus.ram_a_out[12:0]] <= bus.ram_dout_out;
        r_din <= mem[bus.ram_a_out[12:0]];
    end
    assign bus.ram_din_in = r_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_reqs();
        bus.inst_req_in   = 1'b0;
        bus.inst_addr_in  = '0;
        bus.data_req_in   = 1'b0;
        bus.data_rw_in    = 1'b0;
        bus.data_width_in = 2'd0;
        bus.data_sext_in  = 1'b0;
        bus.data_addr_in  = '0;
        bus.data_wdata_in = '0;
    endtask

    task automatic start_data(input logic rw, input logic [1:0] width, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_req_in   = 1'b1;
        bus.data_rw_in    = rw;
        bus.data_width_in = width;
        bus.data_sext_in  = sext;
        bus.data_addr_in  = addr;
        bus.data_wdata_in = wdata;
    endtask

    task automatic start_inst(input logic [31:0] addr);
        bus.inst_req_in  = 1'b1;
        bus.inst_addr_in = addr;
    endtask

    // Counts cycles after the current one until the selected done pulse.
    task automatic wait_done(input bit is_inst, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((is_inst ? bus.inst_done_out : bus.data_done_out) === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sw_word;
        int          n_done;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        rst = 1'b1;
        rdy = 1'b1;
        idle_reqs();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_a", bus.ram_a_out, 32'd0);
        chk("rst_wr", 32'(bus.ram_wr_out), 32'd0);
        chk("rst_done", {30'd0, bus.inst_done_out, bus.data_done_out}, 32'd0);
        chk("rst_rdata", bus.data_rdata_out, 32'd0);
        rst = 1'b0;

        // Word fetch from 0x100
        mem[13'h100] = 8'h11; mem[13'h101] = 8'h22; mem[13'h102] = 8'h33; mem[13'h103] = 8'h44;
        @(negedge clk);
        start_inst(32'h100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fetch_a", bus.ram_a_out, 32'h100 + 32'(k));
            chk("fetch_wr", 32'(bus.ram_wr_out), 32'd0);
        end
        @(negedge clk);
        chk("fetch_early", 32'(bus.inst_done_out), 32'd0);
        @(negedge clk);
        chk("fetch_done", 32'(bus.inst_done_out), 32'd1);
        chk("fetch_data", bus.inst_data_out, 32'h44332211);
        chk("fetch_ddone", 32'(bus.data_done_out), 32'd0);
        idle_reqs();
        @(negedge clk);
        chk("fetch_pulse", 32'(bus.inst_done_out), 32'd0);
        chk("fetch_hold", bus.inst_data_out, 32'h44332211);

        // LB signed, then unsigned
        mem[13'h200] = 8'h80;
        start_data(1'b0, 2'd0, 1'b1, 32'h200, 32'd0);
        wait_done(1'b0, 3, "lb_s");
        chk("lb_s_data", bus.data_rdata_out, 32'hFFFFFF80);
        idle_reqs();
        @(negedge clk);
        start_data(1'b0, 2'd0, 1'b0, 32'h200, 32'd0);
        wait_done(1'b0, 3, "lb_u");
        chk("lb_u_data", bus.data_rdata_out, 32'h00000080);
        idle_reqs();

        // Misaligned word store
        sw_word = 32'hDEADBEEF;
        @(negedge clk);
        start_data(1'b1, 2'd2, 1'b0, 32'h1003, sw_word);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sw_a", bus.ram_a_out, 32'h1003 + 32'(k));
            chk("sw_wr", 32'(bus.ram_wr_out), 32'd1);
            chk("sw_dout", 32'(bus.ram_dout_out), 32'(sw_word[8*k +: 8]));
        end
        @(negedge clk);
        chk("sw_done", 32'(bus.data_done_out), 32'd1);
        chk("sw_wr_done", 32'(bus.ram_wr_out), 32'd0);
        idle_reqs();
        chk("sw_mem", {mem[13'h1006], mem[13'h1005], mem[13'h1004], mem[13'h1003]}, 32'hDEADBEEF);

        // Simultaneous LH and fetch: load first, fetch after
        mem[13'h300] = 8'hFE; mem[13'h301] = 8'hFF;
        mem[13'h000] = 8'h01; mem[13'h001] = 8'h02; mem[13'h002] = 8'h03; mem[13'h003] = 8'h04;
        @(negedge clk);
        start_data(1'b0, 2'd1, 1'b1, 32'h300, 32'd0);
        start_inst(32'h0);
        wait_done(1'b0, 4, "lh_s");
        chk("lh_s_data", bus.data_rdata_out, 32'hFFFFFFFE);
        chk("lh_s_idone", 32'(bus.inst_done_out), 32'd0);
        bus.data_req_in = 1'b0;
        wait_done(1'b1, 7, "fetch2");
        chk("fetch2_data", bus.inst_data_out, 32'h04030201);
        idle_reqs();

        // rdy low for 3 cycles at the beat-2 cycle of a word store
        @(negedge clk);
        start_data(1'b1, 2'd2, 1'b0, 32'h400, 32'h11223344);
        @(negedge clk);
        chk("stall_a0", bus.ram_a_out, 32'h400);
        @(negedge clk);
        chk("stall_a1", bus.ram_a_out, 32'h401);
        @(negedge clk);
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            chk("stall_wr", 32'(bus.ram_wr_out), 32'd0);
            chk("stall_done", 32'(bus.data_done_out), 32'd0);
        end
        @(negedge clk);
        rdy = 1'b1;
        #1;
        chk("stall_a2", bus.ram_a_out, 32'h402);
        chk("stall_wr2", 32'(bus.ram_wr_out), 32'd1);
        chk("stall_d2", 32'(bus.ram_dout_out), 32'h22);
        @(negedge clk);
        chk("stall_a3", bus.ram_a_out, 32'h403);
        chk("stall_d3", 32'(bus.ram_dout_out), 32'h11);
        chk("stall_nodone", 32'(bus.data_done_out), 32'd0);
        @(negedge clk);
        chk("stall_done_end", 32'(bus.data_done_out), 32'd1);
        idle_reqs();
        chk("stall_mem", {mem[13'h403], mem[13'h402], mem[13'h401], mem[13'h400]}, 32'h11223344);

        // Reset pulse at beat 1 of a word store
        mem[13'h501] = 8'h5A;
        @(negedge clk);
        start_data(1'b1, 2'd2, 1'b0, 32'h500, 32'hA5A5A5A5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_reqs();
        #1;
        chk("rstx_wr", 32'(bus.ram_wr_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstx_busy", 32'(bus.busy_out), 32'd0);
        chk("rstx_a", bus.ram_a_out, 32'd0);
        chk("rstx_dout", 32'(bus.ram_dout_out), 32'd0);
        chk("rstx_idata", bus.inst_data_out, 32'd0);
        chk("rstx_rdata", bus.data_rdata_out, 32'd0);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.data_done_out === 1'b1 || bus.inst_done_out === 1'b1) n_done++;
        end
        chk("rstx_nodone", 32'(n_done), 32'd0);
        chk("rstx_mem", {mem[13'h502], mem[13'h501], mem[13'h500]}, 32'h005AA5);

        // Fresh request after the abort
        start_data(1'b0, 2'd0, 1'b0, 32'h1003, 32'd0);
        wait_done(1'b0, 3, "post_rst");
        chk("post_rst_data", bus.data_rdata_out, 32'h000000EF);
        idle_reqs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
